rv_run_monitor: RTL and testbench
=================================

RV_RUN_MONITOR -- requirements
Module: rv_run_monitor

Interface
REQ-001 Parameter XLEN, default 64: datapath width of observed PC, address and data buses.
REQ-002 Parameter CNT_W, default 32: width of every statistics counter.
REQ-003 Parameter HALT_REPEAT, default 4: consecutive unchanged-PC cycles that declare a halt (range 1..255).
REQ-004 Parameter MAX_CYCLES, default 1000: RUN cycle budget before timeout (at least 2, at most 2^CNT_W-1).
REQ-005 Parameter TRACE_DEPTH, default 8: store-trace FIFO entries (power of two, at least 2).
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse that arms or re-arms a run.
REQ-009 pc_out  in  XLEN  processor program counter.
REQ-010 branchfinale  in  1  taken-branch indication for the current instruction.
REQ-011 regwrite  in  1  register-file write enable; rd in 5 gives the destination register.
REQ-012 memwrite  in  1  data-memory store enable; aluout in XLEN is the store address; readdata2 in XLEN is the store data.
REQ-013 state  out  2  run state: IDLE=0, RUN=1, HALTED=2, TIMEOUT=3.
REQ-014 cycle_count, retired_count, branch_count, store_count, regwr_count  out  CNT_W each  statistics counters.
REQ-015 halted, timed_out  out  1 each  level flags, equal to (state==HALTED) and (state==TIMEOUT).
REQ-016 trace_valid out 1, trace_ready in 1, trace_addr out XLEN, trace_data out XLEN, trace_overflow out 1: store-trace port, present only when the Configuration macro is defined.

Function
REQ-017 In IDLE, a start pulse moves state to RUN on the next edge, captures pc_out into prev_pc, and zeroes all counters and the repeat count.
REQ-018 In RUN, each cycle increments cycle_count by 1.
REQ-019 In RUN, retired_count increments when pc_out differs from prev_pc; prev_pc updates to pc_out every RUN cycle.
REQ-020 In RUN, branch_count increments when branchfinale=1; store_count increments when memwrite=1; regwr_count increments when regwrite=1 and rd is not 0.
REQ-021 Repeat count increments when pc_out equals prev_pc and clears otherwise; reaching HALT_REPEAT moves state to HALTED on the next edge.
REQ-022 When cycle_count equals MAX_CYCLES-1 in RUN, state moves to TIMEOUT on the next edge.
REQ-023 If halt and timeout occur in the same cycle, HALTED wins.
REQ-024 Every counter saturates at all-ones and never wraps.
REQ-025 In HALTED and TIMEOUT, all counters freeze.
REQ-026 A start pulse in HALTED or TIMEOUT behaves exactly as in IDLE (REQ-017).
REQ-027 A start pulse in RUN is ignored.
REQ-028 Observed inputs are ignored outside RUN.

Reset
REQ-029 On reset: state=IDLE, all counters=0, prev_pc=0, repeat count=0, halted=0, timed_out=0; the trace FIFO is emptied with trace_valid=0 and trace_overflow=0.
REQ-030 Reset asserted mid-run overrides start and every other input on that edge.

Configuration
REQ-031 Macro RUN_MON_TRACE_EN: when defined, each RUN cycle with memwrite=1 pushes {aluout, readdata2} into a TRACE_DEPTH FIFO.
REQ-032 With RUN_MON_TRACE_EN, trace_valid=1 whenever the FIFO is non-empty; trace_addr and trace_data show the head entry; an entry pops when trace_valid and trace_ready are both 1.
REQ-033 With RUN_MON_TRACE_EN, a push into a full FIFO with no pop in the same cycle is dropped and sets trace_overflow, which is sticky.
REQ-034 With RUN_MON_TRACE_EN, a push and a pop on a full FIFO in the same cycle both succeed.
REQ-035 With RUN_MON_TRACE_EN, a start pulse (REQ-017) empties the FIFO and clears trace_overflow.
REQ-036 Without RUN_MON_TRACE_EN, no trace ports and no FIFO storage exist; all other behaviour is unchanged.

Structure
REQ-037 Package rv_mon_pkg holds the run-state enum encoding (IDLE/RUN/HALTED/TIMEOUT) and the default parameter constants.
REQ-038 The trace FIFO is the sub-module rv_mon_fifo, parametrised by entry width and depth.

Verification
REQ-039 Reset, start, pc_out steps 0,4,8 and then holds at 8 with HALT_REPEAT=4 -> state=HALTED; retired_count=2; cycle_count=7.
REQ-040 MAX_CYCLES=10, start, pc_out increments every cycle -> state=TIMEOUT after 10 RUN cycles; cycle_count=10; timed_out=1.
REQ-041 Halt and timeout fall on the same cycle -> state=HALTED; timed_out=0.
REQ-042 CNT_W=3 with a long run -> cycle_count holds at 7 and does not wrap.
REQ-043 Trace enabled, TRACE_DEPTH=2, trace_ready=0, three stores (addresses 0x10, 0x18, 0x20) -> FIFO holds 0x10 and 0x18; trace_overflow=1; raising trace_ready pops 0x10 then 0x18.
REQ-044 reset asserted mid-RUN while start=1 -> state=IDLE; all counters=0 on the next edge.

Source files
------------

// File: rtl/rv_mon_pkg.sv
// Shared definitions for the run monitor: run-state encoding and the
// default parameter values used by rv_run_monitor.
package rv_mon_pkg;

  // Run-state encoding, visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } run_state_e;

  localparam int DEF_XLEN        = 64;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_HALT_REPEAT = 4;
  localparam int DEF_MAX_CYCLES  = 1000;
  localparam int DEF_TRACE_DEPTH = 8;

endpackage

// File: rtl/rv_mon_fifo.sv
// Store-trace FIFO. Valid/ready: an entry leaves when valid and ready are
// both high on a rising edge. A push into a full FIFO succeeds only if a pop
// happens on the same edge; otherwise it is dropped and overflow is set and
// held until reset or clear.
module rv_mon_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] head,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = valid && ready;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !do_pop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/rv_run_monitor.sv
// Run monitor for a RISC-V style core: watches the PC and write strobes,
// keeps saturating statistics, and detects halt (PC stuck for HALT_REPEAT
// cycles) or timeout (MAX_CYCLES RUN cycles). Halt wins over timeout.
// Optional store trace FIFO is built when RUN_MON_TRACE_EN is defined.
module rv_run_monitor
  import rv_mon_pkg::*;
#(
  parameter int XLEN        = DEF_XLEN,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int HALT_REPEAT = DEF_HALT_REPEAT,
  parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
  parameter int TRACE_DEPTH = DEF_TRACE_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [XLEN-1:0]  pc_out,
  input  logic             branchfinale,
  input  logic             regwrite,
  input  logic [4:0]       rd,
  input  logic             memwrite,
  input  logic [XLEN-1:0]  aluout,
  input  logic [XLEN-1:0]  readdata2,
`ifdef RUN_MON_TRACE_EN
  input  logic             trace_ready,
  output logic             trace_valid,
  output logic [XLEN-1:0]  trace_addr,
  output logic [XLEN-1:0]  trace_data,
  output logic             trace_overflow,
`endif
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] store_count,
  output logic [CNT_W-1:0] regwr_count,
  output logic             halted,
  output logic             timed_out
);

  if (HALT_REPEAT < 1 || HALT_REPEAT > 255) begin : g_bad_halt_repeat
    $error("HALT_REPEAT must be in 1..255");
  end
  if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_trace_depth
    $error("TRACE_DEPTH must be a power of two, at least 2");
  end

  run_state_e      st;
  logic [XLEN-1:0] prev_pc;
  logic [7:0]      repeat_cnt;
  logic [7:0]      repeat_next;
  logic            pc_same;
  logic            halt_hit;
  logic            timeout_hit;
  logic            arm;

  assign state = st;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  // Halt/timeout detection for the current RUN cycle.
  always_comb begin
    pc_same     = (pc_out == prev_pc);
    repeat_next = pc_same ? repeat_cnt + 8'd1 : 8'd0;
    halt_hit    = pc_same && (repeat_next == 8'(HALT_REPEAT));
    timeout_hit = (cycle_count == CNT_W'(MAX_CYCLES - 1));
    arm         = start && (st != ST_RUN);
  end

  // Run-state FSM with counters and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      st            <= ST_IDLE;
      prev_pc       <= '0;
      repeat_cnt    <= '0;
      cycle_count   <= '0;
      retired_count <= '0;
      branch_count  <= '0;
      store_count   <= '0;
      regwr_count   <= '0;
      halted        <= 1'b0;
      timed_out     <= 1'b0;
    end else begin
      case (st)
        ST_RUN: begin
          cycle_count   <= sat_inc(cycle_count, 1'b1);
          retired_count <= sat_inc(retired_count, !pc_same);
          branch_count  <= sat_inc(branch_count, branchfinale);
          store_count   <= sat_inc(store_count, memwrite);
          regwr_count   <= sat_inc(regwr_count, regwrite && (rd != 5'd0));
          prev_pc       <= pc_out;
          repeat_cnt    <= repeat_next;
          if (halt_hit) begin
            st     <= ST_HALTED;
            halted <= 1'b1;
          end else if (timeout_hit) begin
            st        <= ST_TIMEOUT;
            timed_out <= 1'b1;
          end
        end
        default: begin
          // IDLE, HALTED and TIMEOUT all re-arm identically on start.
          if (start) begin
            st            <= ST_RUN;
            prev_pc       <= pc_out;
            repeat_cnt    <= '0;
            cycle_count   <= '0;
            retired_count <= '0;
            branch_count  <= '0;
            store_count   <= '0;
            regwr_count   <= '0;
            halted        <= 1'b0;
            timed_out     <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef RUN_MON_TRACE_EN
  logic [2*XLEN-1:0] trace_head;

  rv_mon_fifo #(
    .W     (2 * XLEN),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (arm),
    .push      ((st == ST_RUN) && memwrite),
    .push_data ({aluout, readdata2}),
    .ready     (trace_ready),
    .valid     (trace_valid),
    .head      (trace_head),
    .overflow  (trace_overflow)
  );

  assign trace_addr = trace_head[2*XLEN-1:XLEN];
  assign trace_data = trace_head[XLEN-1:0];
`else
  logic unused_trace;
  assign unused_trace = ^{aluout, readdata2, arm};
`endif

endmodule

// File: tb/tb_rv_run_monitor.sv
// Bench for rv_run_monitor. Two instances share stimulus: dut_a (CNT_W=32,
// MAX_CYCLES=10) and dut_s (CNT_W=3, MAX_CYCLES=7). Trace checks are
// compiled in when RUN_MON_TRACE_EN is defined.
module tb_rv_run_monitor;

  // ---------------- clock / reset / stimulus signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic [63:0] pc_out;
  logic        branchfinale;
  logic        regwrite;
  logic [4:0]  rd;
  logic        memwrite;
  logic [63:0] aluout;
  logic [63:0] readdata2;

  logic [1:0]  state_a;
  logic [31:0] cyc_a, ret_a, br_a, st_a, rw_a;
  logic        halted_a, to_a;

  logic [1:0]  state_s;
  logic [2:0]  cyc_s, ret_s, br_s, st_s, rw_s;
  logic        halted_s, to_s;

`ifdef RUN_MON_TRACE_EN
  logic        trace_ready;
  logic        tv_a, tov_a, tv_s, tov_s;
  logic [63:0] ta_a, td_a, ta_s, td_s;
`endif

  rv_run_monitor #(
    .XLEN(64), .CNT_W(32), .HALT_REPEAT(4), .MAX_CYCLES(10), .TRACE_DEPTH(2)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start), .pc_out(pc_out),
    .branchfinale(branchfinale), .regwrite(regwrite), .rd(rd),
    .memwrite(memwrite), .aluout(aluout), .readdata2(readdata2),
`ifdef RUN_MON_TRACE_EN
    .trace_ready(trace_ready), .trace_valid(tv_a), .trace_addr(ta_a),
    .trace_data(td_a), .trace_overflow(tov_a),
`endif
    .state(state_a), .cycle_count(cyc_a), .retired_count(ret_a),
    .branch_count(br_a), .store_count(st_a), .regwr_count(rw_a),
    .halted(halted_a), .timed_out(to_a)
  );

  rv_run_monitor #(
    .XLEN(64), .CNT_W(3), .HALT_REPEAT(4), .MAX_CYCLES(7), .TRACE_DEPTH(2)
  ) dut_s (
    .clk(clk), .reset(reset), .start(start), .pc_out(pc_out),
    .branchfinale(branchfinale), .regwrite(regwrite), .rd(rd),
    .memwrite(memwrite), .aluout(aluout), .readdata2(readdata2),
`ifdef RUN_MON_TRACE_EN
    .trace_ready(trace_ready), .trace_valid(tv_s), .trace_addr(ta_s),
    .trace_data(td_s), .trace_overflow(tov_s),
`endif
    .state(state_s), .cycle_count(cyc_s), .retired_count(ret_s),
    .branch_count(br_s), .store_count(st_s), .regwr_count(rw_s),
    .halted(halted_s), .timed_out(to_s)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] cur_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check_next(input string tag, input logic [63:0] got);
    if (exp_q.size() == 0) check({tag, "_no_expect"}, got, {64{1'bx}});
    else check(tag, got, exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [63:0] p, input logic br, input logic rw,
                       input logic [4:0] r, input logic mw,
                       input logic [63:0] a, input logic [63:0] d);
    pc_out = p; branchfinale = br; regwrite = rw; rd = r;
    memwrite = mw; aluout = a; readdata2 = d;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    drive(cur_pc, 1'b0, 1'b0, 5'd0, 1'b0, 64'd0, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_cycle(); idle_cycle();
    reset = 1'b0;
  endtask

  task automatic do_start(input logic [63:0] p);
    cur_pc = p;
    start = 1'b1;
    idle_cycle();
    start = 1'b0;
  endtask

  task automatic step_pc();
    cur_pc = cur_pc + 64'd4;
    idle_cycle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int e_br, e_st, e_rw, n_stored;
    logic        r_br, r_rw, r_mw;
    logic [4:0]  r_rd;

    reset = 1'b0; start = 1'b0; cur_pc = '0;
    pc_out = '0; branchfinale = 1'b0; regwrite = 1'b0; rd = '0;
    memwrite = 1'b0; aluout = '0; readdata2 = '0;
`ifdef RUN_MON_TRACE_EN
    trace_ready = 1'b0;
`endif

    // Reset state.
    do_reset();
    check("rst_state", state_a, 0);
    check("rst_cycle", cyc_a, 0);
    check("rst_retired", ret_a, 0);
    check("rst_halted", halted_a, 0);
    check("rst_timed_out", to_a, 0);
    check("rst_cycle_s", cyc_s, 0);
`ifdef RUN_MON_TRACE_EN
    check("rst_trace_valid", tv_a, 0);
    check("rst_trace_ovf", tov_a, 0);
`endif

    // PC 0,4,8 then stuck at 8: halt after seven RUN cycles.
    do_start(64'd0);
    drive(64'd0, 0, 0, 0, 0, 0, 0);
    drive(64'd4, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(64'd8, 0, 0, 0, 0, 0, 0);
    check("halt_not_yet", state_a, 1);
    drive(64'd8, 0, 0, 0, 0, 0, 0);
    expect_val(2); expect_val(2); expect_val(7); expect_val(1); expect_val(0);
    check_next("halt_state", state_a);
    check_next("halt_retired", ret_a);
    check_next("halt_cycle", cyc_a);
    check_next("halt_flag", halted_a);
    check_next("halt_timed_out", to_a);

    // Inputs are ignored while HALTED.
    cur_pc = 64'h40;
    for (int i = 0; i < 3; i++) begin
      cur_pc = cur_pc + 64'd4;
      drive(cur_pc, 1, 1, 5'd3, 1, 64'h99, 64'h77);
    end
    check("frozen_cycle", cyc_a, 7);
    check("frozen_branch", br_a, 0);
    check("frozen_state", state_a, 2);

    // Start from HALTED re-arms and clears counters.
    do_start(64'h200);
    check("rearm_state", state_a, 1);
    check("rearm_cycle", cyc_a, 0);
    check("rearm_halted", halted_a, 0);

    // Reset mid-RUN with start high wins.
    step_pc(); step_pc();
    reset = 1'b1; start = 1'b1;
    step_pc();
    reset = 1'b0; start = 1'b0;
    check("midrst_state", state_a, 0);
    check("midrst_cycle", cyc_a, 0);
    check("midrst_store", st_a, 0);
    step_pc();
    check("midrst_stay_idle", state_a, 0);

    // Timeout: PC increments every cycle, MAX_CYCLES=10.
    do_reset();
    do_start(64'd0);
    for (int i = 0; i < 9; i++) step_pc();
    check("to_not_yet", state_a, 1);
    step_pc();
    expect_val(3); expect_val(10); expect_val(1); expect_val(0);
    check_next("to_state", state_a);
    check_next("to_cycle", cyc_a);
    check_next("to_flag", to_a);
    check_next("to_halted", halted_a);

    // Halt and timeout on the same cycle: halt wins.
    do_start(64'd0);
    for (int i = 0; i < 6; i++) step_pc();
    for (int i = 0; i < 4; i++) idle_cycle();
    expect_val(2); expect_val(0); expect_val(1); expect_val(10);
    check_next("tie_state", state_a);
    check_next("tie_timed_out", to_a);
    check_next("tie_halted", halted_a);
    check_next("tie_cycle", cyc_a);

    // Random activity with PC always advancing; start in RUN is ignored.
    do_reset();
    do_start(64'h100);
    e_br = 0; e_st = 0; e_rw = 0;
    for (int i = 0; i < 8; i++) begin
      cur_pc = cur_pc + 64'(4 * $urandom_range(1, 3));
      r_br = 1'($urandom_range(0, 1));
      r_rw = 1'($urandom_range(0, 1));
      r_mw = 1'($urandom_range(0, 1));
      r_rd = 5'($urandom_range(0, 3));
      e_br += int'(r_br);
      e_st += int'(r_mw);
      e_rw += int'(r_rw && (r_rd != 5'd0));
      drive(cur_pc, r_br, r_rw, r_rd, r_mw, cur_pc, 64'(i));
    end
    start = 1'b1;
    step_pc();
    start = 1'b0;
    expect_val(1); expect_val(9); expect_val(9);
    expect_val(64'(e_br)); expect_val(64'(e_st)); expect_val(64'(e_rw));
    check_next("rnd_state", state_a);
    check_next("rnd_cycle", cyc_a);
    check_next("rnd_retired", ret_a);
    check_next("rnd_branch", br_a);
    check_next("rnd_store", st_a);
    check_next("rnd_regwr", rw_a);

    // Narrow counters: long run on dut_s stops at 7, never wraps.
    do_reset();
    do_start(64'd0);
    for (int i = 0; i < 20; i++) begin
      cur_pc = cur_pc + 64'd4;
      drive(cur_pc, 1, 1, 5'd1, 0, 0, 0);
    end
    check("sat_cycle", cyc_s, 7);
    check("sat_branch", br_s, 7);
    check("sat_state", state_s, 3);
    check("sat_timed_out", to_s, 1);

`ifdef RUN_MON_TRACE_EN
    // Three stores into a depth-2 FIFO with no consumer.
    do_reset();
    trace_ready = 1'b0;
    do_start(64'd0);
    check("tr_start_valid", tv_a, 0);
    n_stored = 0;
    for (int i = 0; i < 3; i++) begin
      cur_pc = cur_pc + 64'd4;
      if (n_stored < 2) begin
        expect_val(64'h10 + 64'(8 * i));
        expect_val(64'hA0 + 64'(i));
        n_stored++;
      end
      drive(cur_pc, 0, 0, 0, 1, 64'h10 + 64'(8 * i), 64'hA0 + 64'(i));
    end
    check("tr_overflow", tov_a, 1);
    check("tr_valid", tv_a, 1);
    trace_ready = 1'b1;
    for (int i = 0; i < 6 && tv_a; i++) begin
      check_next("tr_addr", ta_a);
      check_next("tr_data", td_a);
      step_pc();
    end
    check("tr_drained", 64'(exp_q.size()), 0);
    check("tr_empty_valid", tv_a, 0);
    check("tr_sticky_ovf", tov_a, 1);
    for (int i = 0; i < 12 && state_a == 2'd1; i++) step_pc();
    do_start(cur_pc);
    check("tr_start_clear_ovf", tov_a, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard ceiling so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
